// File: rtl/camellia_pkg.sv
// Shared types, key-slice positions and FL/FL^-1 helpers for the Camellia-128
// encryption sequencer.
package camellia_pkg;

  localparam int HALF_W = 64;
  localparam int SUB_W  = 32;
  localparam int KW_W   = 256;
  localparam int KE_W   = 256;
  localparam int KR_W   = 1152;
  localparam int RGK_W  = 384;
  localparam int KEP_W  = 128;

  // MSB positions of each 64-bit whitening key inside KW
  localparam int KW1_MSB = 255;
  localparam int KW2_MSB = 191;
  localparam int KW3_MSB = 127;
  localparam int KW4_MSB = 63;

  // MSB positions of each 128-bit {ke_a,ke_b} pair inside KE
  localparam int KE12_MSB = 255;
  localparam int KE34_MSB = 127;

  // MSB positions of the six round keys used by each pass inside KR
  localparam int KR_P0_MSB = 1151;
  localparam int KR_P1_MSB = 767;
  localparam int KR_P2_MSB = 383;

  typedef logic [HALF_W-1:0] half_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [SUB_W-1:0] rotl1(input logic [SUB_W-1:0] x);
    return {x[SUB_W-2:0], x[SUB_W-1]};
  endfunction

  function automatic half_t fl(input half_t x, input half_t k);
    logic [SUB_W-1:0] yl;
    logic [SUB_W-1:0] yr;
    yr = rotl1(x[63:32] & k[63:32]) ^ x[31:0];
    yl = (yr | k[31:0]) ^ x[63:32];
    return {yl, yr};
  endfunction

  function automatic half_t fl_inv(input half_t y, input half_t k);
    logic [SUB_W-1:0] xl;
    logic [SUB_W-1:0] xr;
    xl = (y[31:0] | k[31:0]) ^ y[63:32];
    xr = rotl1(xl & k[63:32]) ^ y[31:0];
    return {xl, xr};
  endfunction

endpackage

// File: rtl/camellia_fl_layer.sv
// Combinational FL on the left half and FL^-1 on the right half; the caller
// muxes in {ke1,ke2} or {ke3,ke4} so one instance serves both FL layers.
module camellia_fl_layer
  import camellia_pkg::*;
(
  input  half_t             i_l,
  input  half_t             i_r,
  input  logic [KEP_W-1:0]  i_ke,
  output half_t             o_l,
  output half_t             o_r
);

  assign o_l = fl(i_l, i_ke[KEP_W-1:HALF_W]);
  assign o_r = fl_inv(i_r, i_ke[HALF_W-1:0]);

endmodule

// File: rtl/camellia_enc_sequencer.sv
// Iterative Camellia-128 encryption wrapper: whitening, three passes through an
// external six-round group, FL layers between passes, output whitening.
module camellia_enc_sequencer
  import camellia_pkg::*;
#(
  parameter int RG_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [127:0]      PT,
  input  logic [KW_W-1:0]   KW,
  input  logic [KE_W-1:0]   KE,
  input  logic [KR_W-1:0]   KR,
  output logic [HALF_W-1:0] RG_L,
  output logic [HALF_W-1:0] RG_R,
  output logic [RGK_W-1:0]  RG_K,
  input  logic [HALF_W-1:0] RG_OUT_L,
  input  logic [HALF_W-1:0] RG_OUT_R,
  output logic [127:0]      CT,
  output logic              DONE,
  output logic              BUSY
);

  localparam int WW = (RG_LAT > 0) ? $clog2(RG_LAT + 1) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(RG_LAT);

  state_t           r_state;
  logic [1:0]       r_pass;
  logic [WW-1:0]    r_wcnt;
  half_t            r_d1;
  half_t            r_d2;
  logic [127:0]     r_ct;
  logic             r_done;

  logic [KEP_W-1:0] w_ke;
  half_t            w_fl_l;
  half_t            w_fl_r;

  // Pass 0 uses ke1/ke2; pass 1 uses ke3/ke4. Pass 2 never captures FL output.
  assign w_ke = (r_pass == 2'd0) ? KE[KE12_MSB -: KEP_W] : KE[KE34_MSB -: KEP_W];

  camellia_fl_layer u_fl (
    .i_l  (RG_OUT_L),
    .i_r  (RG_OUT_R),
    .i_ke (w_ke),
    .o_l  (w_fl_l),
    .o_r  (w_fl_r)
  );

  always_comb begin
    RG_K = KR[KR_P2_MSB -: RGK_W];
    case (r_pass)
      2'd0:    RG_K = KR[KR_P0_MSB -: RGK_W];
      2'd1:    RG_K = KR[KR_P1_MSB -: RGK_W];
      default: RG_K = KR[KR_P2_MSB -: RGK_W];
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_pass  <= '0;
      r_wcnt  <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_ct    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_d1    <= PT[127:64] ^ KW[KW1_MSB -: HALF_W];
            r_d2    <= PT[63:0]   ^ KW[KW2_MSB -: HALF_W];
            r_pass  <= '0;
            r_wcnt  <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_wcnt == W_LAST) begin
            r_wcnt <= '0;
            if (r_pass == 2'd2) begin
              // Final swap: right half leads the ciphertext
              r_ct    <= {RG_OUT_R ^ KW[KW3_MSB -: HALF_W],
                          RG_OUT_L ^ KW[KW4_MSB -: HALF_W]};
              r_done  <= 1'b1;
              r_pass  <= '0;
              r_state <= IDLE;
            end else begin
              r_d1   <= w_fl_l;
              r_d2   <= w_fl_r;
              r_pass <= r_pass + 2'd1;
            end
          end else begin
            r_wcnt <= r_wcnt + WW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign RG_L = r_d1;
  assign RG_R = r_d2;
  assign CT   = r_ct;
  assign DONE = r_done;
  assign BUSY = (r_state == RUN);

endmodule

// File: tb/tb_camellia_enc_sequencer.sv
// Directed bench for camellia_enc_sequencer using an identity six-round stub
// (one register stage, matching RG_LAT=1).
module tb_camellia_enc_sequencer;

  typedef struct {
    string          name;
    logic [127:0]   pt;
    logic [255:0]   kw;
    logic [255:0]   ke;
    logic [127:0]   ct;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [127:0]  pt;
  logic [255:0]  kw;
  logic [255:0]  ke;
  logic [1151:0] kr;
  logic [63:0]   rg_l, rg_r, rg_out_l, rg_out_r;
  logic [383:0]  rg_k;
  logic [127:0]  ct;
  logic          done, busy;

  int n_cmp = 0;
  int n_err = 0;

  camellia_enc_sequencer #(.RG_LAT(1)) dut (
    .CLK(clk), .RST(rst_n), .START(start), .PT(pt), .KW(kw), .KE(ke), .KR(kr),
    .RG_L(rg_l), .RG_R(rg_r), .RG_K(rg_k), .RG_OUT_L(rg_out_l), .RG_OUT_R(rg_out_r),
    .CT(ct), .DONE(done), .BUSY(busy)
  );

  // Identity six-round group with a single output register
  always_ff @(posedge clk) begin
    rg_out_l <= rg_l;
    rg_out_r <= rg_r;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [383:0] kexp(input int p);
    logic [383:0] r;
    r = '0;
    for (int j = 0; j < 6; j++) r[383-64*j -: 64] = 64'(6*p + j + 1);
    return r;
  endfunction

  // Accept one request, then wait (bounded) for DONE; lat = cycles after the accepting edge
  task automatic run_vec(input vec_t v, output int lat);
    pt = v.pt; kw = v.kw; ke = v.ke; start = 1'b1;
    step();
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  vec_t vecs[4];

  initial begin
    int lat;
    int n_pass1;
    int n_done;
    int first_lat;
    logic [127:0] first_ct;

    vecs[0] = '{"zero_data", 128'h0,
                {64'h0, 64'h0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210},
                256'h0,
                128'h0123456789ABCDEF_FEDCBA9876543210};
    vecs[1] = '{"zero_ke_swap", 128'h11111111_22222222_33333333_44444444,
                256'h0, 256'h0,
                128'h33333333_44444444_11111111_22222222};
    vecs[2] = '{"ones_ke", 128'h00000001_00000000_00000000_00000001,
                256'h0, {256{1'b1}},
                128'h00000000_FFFFFFFE_00000001_FFFFFFFF};
    vecs[3] = '{"mixed_keys", 128'h0,
                {64'h80000000_00000000, 64'h00000000_80000000,
                 64'hFFFFFFFF_00000000, 64'h00000000_FFFFFFFF},
                {64'h80000000_00000000, 64'hFFFFFFFF_00000000,
                 64'h00000000_FFFFFFFF, 64'h0F0F0F0F_F0F0F0F0},
                128'h8F0F0F0E_80000003_7FFFFFFE_FFFFFFFE};

    for (int i = 1; i <= 18; i++) kr[1151-64*(i-1) -: 64] = 64'(i);
    start = 1'b0; pt = '0; kw = '0; ke = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ct",   384'(ct),   384'h0);
    chk("rst_done", 384'(done), 384'h0);
    chk("rst_busy", 384'(busy), 384'h0);
    chk("rst_rg_l", 384'(rg_l), 384'h0);
    chk("rst_rg_r", 384'(rg_r), 384'h0);
    chk("rst_rg_k", rg_k,       kexp(0));
    step(); step();
    rst_n = 1'b1;
    step();

    // Table-driven vectors: ciphertext and DONE latency
    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], lat);
      chk({vecs[i].name, "_lat"}, 384'(lat), 384'd6);
      chk({vecs[i].name, "_ct"},  384'(ct),  384'(vecs[i].ct));
      step();
      chk({vecs[i].name, "_done_pulse"}, 384'(done), 384'h0);
    end

    // Per-pass RG_K selection and RG_L/RG_R holding
    pt = vecs[3].pt; kw = vecs[3].kw; ke = vecs[3].ke; start = 1'b1;
    step();
    start = 1'b0;
    n_pass1 = 0;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) step();
      if (rg_k === kexp(1)) n_pass1++;
      if (c == 0) chk("busy_after_accept", 384'(busy), 384'h1);
      if (c <= 1) chk("rg_k_pass0", rg_k, kexp(0));
      if (c == 4 || c == 5) chk("rg_k_pass2", rg_k, kexp(2));
      if (c <= 1) chk("rg_lr_pass0", 384'({rg_l, rg_r}),
                      384'(128'h80000000_00000000_00000000_80000000));
      if (c == 2 || c == 3) chk("rg_lr_pass1", 384'({rg_l, rg_r}),
                      384'(128'h80000001_00000001_80000000_80000001));
      if (c == 6) chk("done_at_6", 384'(done), 384'h1);
    end
    chk("rg_k_pass1_cycles", 384'(n_pass1), 384'd2);

    // START while busy is ignored
    pt = vecs[1].pt; kw = vecs[1].kw; ke = vecs[1].ke; start = 1'b1;
    step();
    start = 1'b0;
    n_done = 0; first_lat = -1; first_ct = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        pt = vecs[2].pt;
        start = 1'b1;
      end
      step();
      start = 1'b0;
      if (done) begin
        n_done++;
        if (first_lat < 0) begin
          first_lat = c;
          first_ct = ct;
        end
      end
    end
    chk("busy_start_done_count", 384'(n_done),    384'd1);
    chk("busy_start_lat",        384'(first_lat), 384'd6);
    chk("busy_start_ct",         384'(first_ct),  384'(vecs[1].ct));

    // Back-to-back: START in the DONE cycle
    run_vec(vecs[0], lat);
    chk("b2b_first_ct", 384'(ct), 384'(vecs[0].ct));
    pt = vecs[1].pt; kw = vecs[1].kw; ke = vecs[1].ke; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy", 384'(busy), 384'h1);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done) begin
        lat = c;
        break;
      end
      chk("b2b_ct_held", 384'(ct), 384'(vecs[0].ct));
    end
    chk("b2b_second_lat", 384'(lat), 384'd6);
    chk("b2b_second_ct",  384'(ct),  384'(vecs[1].ct));

    // Asynchronous reset in the middle of a run
    step();
    pt = vecs[3].pt; kw = vecs[3].kw; ke = vecs[3].ke; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ct",   384'(ct),   384'h0);
    chk("midrst_busy", 384'(busy), 384'h0);
    chk("midrst_done", 384'(done), 384'h0);
    chk("midrst_rg",   384'({rg_l, rg_r}), 384'h0);
    step(); step();
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (done) n_done++;
    end
    chk("midrst_no_done", 384'(n_done), 384'd0);
    chk("midrst_idle",    384'(busy),   384'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
